store_issue_phase: RTL and testbench
====================================

Name: store_issue_phase

Overview:
- Memory-side issue stage between execute and the data memory. It is the writer counterpart of write-back's load path.
- Converts execute-stage micro-ops into word-addressed memory requests:
  - loads: single beat; byte offset forwarded to write-back as ew_ld_offset.
  - stores: data aligned and byte-enabled; stores crossing a 64-bit word boundary are split into two beats, with upstream stall during the split.

Parameters:
- ADDR_W_P, `ADDR_W, byte-address width.
- BEAT_BYTES, 8, bytes per memory word (DATA_W/8); fixed at 8.

Ports:
- clk  in  1  clock
- rstn  in  1  asynchronous active-low reset
- ex_opcode  in  `OPCODE_W  micro-op from execute; only `MICRO_SB/`MICRO_SD/`MICRO_SQ/`MICRO_LB/`MICRO_LD/`MICRO_LQ act, all others are no-ops
- ex_addr  in  `ADDR_W  byte address
- ex_st_data  in  `REG_W  store source, little-endian, LSB first
- flush  in  1  kill the incoming op this cycle
- mem_we  out  1  write strobe
- mem_re  out  1  read strobe
- mem_addr  out  `ADDR_W  word address = byte address >> 3
- mem_wdata  out  `DATA_W  aligned write data
- mem_be  out  8  byte enables, bit k = byte k
- ew_ld_offset  out  3  byte offset of the issued load, to write-back
- stall_st  out  1  upstream must hold ex_* next cycle

Behaviour:
- Clock and reset: one clock, clk; reset rstn asynchronous active-low.
- Reset values: all outputs 0; FSM in IDLE; pending-beat registers 0.
- Latency and sizes:
  - All outputs registered; request appears 1 cycle after the op is presented.
  - Size n: SB=1, SD=4, SQ=8 (LB/LD/LQ same sizes).
  - off = ex_addr[2:0]; mask = (1<<n)-1.
- Beat 0 of a store:
  - mem_addr = ex_addr>>3
  - mem_be = (mask<<off)[7:0]
  - mem_wdata = (ex_st_data<<(8*off))[63:0]
  - mem_we = 1
- Split condition: off+n > 8 → FSM to SPLIT; stall_st = 1 in the same registered cycle as beat 0.
- SPLIT state:
  - emits beat 1: mem_addr = beat0 addr + 1 (wraps modulo 2^ADDR_W), mem_be = mask>>(8-off), mem_wdata = ex_st_data>>(8*(8-off)), both taken from the registered copy.
  - stall_st = 0; return to IDLE.
  - incoming ex_* is ignored, since upstream held it; the held op issues on the following cycle.
- Loads:
  - mem_re = 1, mem_addr = ex_addr>>3, ew_ld_offset = off, mem_be = 0, mem_wdata = 0.
  - Never split; a boundary-crossing load returns only low-word bytes, consistent with write-back's shift.
- Non-memory opcode: mem_we = mem_re = 0; mem_addr/mem_wdata/mem_be/ew_ld_offset hold previous values.
- flush:
  - In IDLE: incoming op is discarded, producing no strobe that cycle.
  - In SPLIT: flush does NOT cancel beat 1, because the store is older than the branch.
- Reset asserted mid-SPLIT: beat 1 is dropped; outputs go to 0 immediately (asynchronous).
- mem_we and mem_re are never both 1.

Optional Feature:
- Macro: STORE_ISSUE_PERF_EN.
- When defined:
  - adds outputs st_beat_cnt (32, count of cycles with mem_we=1) and st_split_cnt (32, count of SPLIT entries).
  - both counters saturate at 2^32-1 and reset to 0.
- When undefined: ports and counters absent; behaviour otherwise identical.

Decomposition:
- Shared package / common_params.h: micro-op codes (existing), size-decode constants, FSM state typedef {IDLE, SPLIT}.
- One sub-module: store_aligner. Combinational; inputs data, off, n; outputs both beats' wdata/be plus a split flag. The FSM and registers stay in store_issue_phase.

Test Plan:
- SQ at addr 0x10, data 0x1122334455667788 → next cycle: mem_addr=0x2, mem_be=0xFF, mem_wdata=0x1122334455667788, mem_we=1, stall_st=0.
- SB at addr 0x0D, data 0xAB → mem_addr=0x1, mem_be=0x20, mem_wdata=0x0000AB0000000000.
- SD at addr 0x06, data 0xDDCCBBAA:
  - cycle 1: mem_addr=0x0, mem_be=0xC0, mem_wdata=0xBBAA000000000000, stall_st=1.
  - cycle 2: mem_addr=0x1, mem_be=0x03, mem_wdata=0x000000000000DDCC, stall_st=0.
- LB at addr 0x23 → mem_re=1, mem_addr=0x4, ew_ld_offset=3, mem_we=0.
- Split SQ at addr 0x05 with flush pulsed in SPLIT cycle → beat 1 still issued (mem_addr=0x1, mem_be=0x1F). SB presented together with flush in IDLE → no strobe.
- rstn dropped during SPLIT → all outputs 0 without a clock edge; after release the first op issues normally from IDLE.

Source files
------------

// File: rtl/store_issue_phase_pkg.sv
// Shared micro-op codes, access-size constants and issue FSM states for the store issue stage.
package store_issue_phase_pkg;

    localparam int ADDR_W   = 32;
    localparam int OPCODE_W = 8;
    localparam int REG_W    = 64;
    localparam int DATA_W   = 64;

    localparam logic [OPCODE_W-1:0] MICRO_LB = 8'h10;
    localparam logic [OPCODE_W-1:0] MICRO_LD = 8'h11;
    localparam logic [OPCODE_W-1:0] MICRO_LQ = 8'h12;
    localparam logic [OPCODE_W-1:0] MICRO_SB = 8'h20;
    localparam logic [OPCODE_W-1:0] MICRO_SD = 8'h21;
    localparam logic [OPCODE_W-1:0] MICRO_SQ = 8'h22;

    localparam logic [3:0] SIZE_B = 4'd1;
    localparam logic [3:0] SIZE_D = 4'd4;
    localparam logic [3:0] SIZE_Q = 4'd8;

    typedef enum logic {
        IDLE  = 1'b0,
        SPLIT = 1'b1
    } issue_state_t;

    function automatic logic [3:0] op_size(input logic [OPCODE_W-1:0] op);
        case (op)
            MICRO_SB, MICRO_LB: op_size = SIZE_B;
            MICRO_SD, MICRO_LD: op_size = SIZE_D;
            MICRO_SQ, MICRO_LQ: op_size = SIZE_Q;
            default:            op_size = 4'd0;
        endcase
    endfunction

    function automatic logic is_store(input logic [OPCODE_W-1:0] op);
        is_store = (op == MICRO_SB) || (op == MICRO_SD) || (op == MICRO_SQ);
    endfunction

    function automatic logic is_load(input logic [OPCODE_W-1:0] op);
        is_load = (op == MICRO_LB) || (op == MICRO_LD) || (op == MICRO_LQ);
    endfunction

endpackage

// File: rtl/store_issue_phase_if.sv
// Execute-side op bundle plus memory request / write-back offset outputs of the store issue stage.
interface store_issue_phase_if
    import store_issue_phase_pkg::*;
#(
    parameter int AW = ADDR_W
);
    logic [OPCODE_W-1:0] ex_opcode;
    logic [AW-1:0]       ex_addr;
    logic [REG_W-1:0]    ex_st_data;
    logic                flush;
    logic                mem_we;
    logic                mem_re;
    logic [AW-1:0]       mem_addr;
    logic [DATA_W-1:0]   mem_wdata;
    logic [7:0]          mem_be;
    logic [2:0]          ew_ld_offset;
    logic                stall_st;

    modport master (
        input  ex_opcode, ex_addr, ex_st_data, flush,
        output mem_we, mem_re, mem_addr, mem_wdata, mem_be, ew_ld_offset, stall_st
    );

    modport slave (
        output ex_opcode, ex_addr, ex_st_data, flush,
        input  mem_we, mem_re, mem_addr, mem_wdata, mem_be, ew_ld_offset, stall_st
    );
endinterface

// File: rtl/store_issue_phase_aligner.sv
// store_aligner: combinational byte-lane alignment of store data into low-word and high-word beats.
// split is set when the access spills past the end of the 8-byte word.
module store_aligner
    import store_issue_phase_pkg::*;
(
    input  logic [DATA_W-1:0] data,
    input  logic [2:0]        off,
    input  logic [3:0]        n,
    output logic [DATA_W-1:0] wdata0,
    output logic [DATA_W-1:0] wdata1,
    output logic [7:0]        be0,
    output logic [7:0]        be1,
    output logic              split
);
    logic [15:0] mask;
    logic [3:0]  off4;
    logic [6:0]  bit_off;

    always_comb begin
        off4    = {1'b0, off};
        bit_off = {1'b0, off, 3'b000};
        mask    = (16'd1 << n) - 16'd1;
        be0     = 8'(mask << off);
        // off == 0 shifts by the full width, leaving beat 1 empty
        be1     = 8'(mask >> (4'd8 - off4));
        wdata0  = data << bit_off;
        wdata1  = data >> (7'd64 - bit_off);
        split   = (off4 + n) > 4'd8;
    end
endmodule

// File: rtl/store_issue_phase.sv
// Registered load/store issue to word-addressed memory, 1 cycle; word-crossing stores split into two beats.
// stall_st asks upstream to hold ex_* while beat 1 issues; perf counters under STORE_ISSUE_PERF_EN.
module store_issue_phase
    import store_issue_phase_pkg::*;
#(
    parameter int ADDR_W_P   = ADDR_W,
    parameter int BEAT_BYTES = 8
)(
    input  logic                clk,
    input  logic                rstn,
    store_issue_phase_if.master bus
`ifdef STORE_ISSUE_PERF_EN
    ,
    output logic [31:0]         st_beat_cnt,
    output logic [31:0]         st_split_cnt
`endif
);
    localparam int OFF_W = $clog2(BEAT_BYTES);

    issue_state_t         state_q, state_d;
    logic                 we_q, we_d;
    logic                 re_q, re_d;
    logic [ADDR_W_P-1:0]  addr_q, addr_d;
    logic [DATA_W-1:0]    wdata_q, wdata_d;
    logic [7:0]           be_q, be_d;
    logic [2:0]           off_q, off_d;
    logic                 stall_q, stall_d;
    logic [DATA_W-1:0]    pend_wdata_q, pend_wdata_d;
    logic [7:0]           pend_be_q, pend_be_d;

    logic [OFF_W-1:0]     ex_off;
    logic [3:0]           ex_n;
    logic                 ex_st, ex_ld;
    logic [DATA_W-1:0]    al_wdata0, al_wdata1;
    logic [7:0]           al_be0, al_be1;
    logic                 al_split;

    assign ex_off = bus.ex_addr[OFF_W-1:0];
    assign ex_n   = op_size(bus.ex_opcode);
    assign ex_st  = is_store(bus.ex_opcode);
    assign ex_ld  = is_load(bus.ex_opcode);

    store_aligner u_aligner (
        .data   (bus.ex_st_data),
        .off    (ex_off),
        .n      (ex_n),
        .wdata0 (al_wdata0),
        .wdata1 (al_wdata1),
        .be0    (al_be0),
        .be1    (al_be1),
        .split  (al_split)
    );

    always_comb begin
        state_d      = state_q;
        we_d         = 1'b0;
        re_d         = 1'b0;
        stall_d      = 1'b0;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        be_d         = be_q;
        off_d        = off_q;
        pend_wdata_d = pend_wdata_q;
        pend_be_d    = pend_be_q;

        case (state_q)
            IDLE: begin
                if (!bus.flush && ex_st) begin
                    we_d         = 1'b1;
                    addr_d       = bus.ex_addr >> 3;
                    be_d         = al_be0;
                    wdata_d      = al_wdata0;
                    pend_be_d    = al_be1;
                    pend_wdata_d = al_wdata1;
                    if (al_split) begin
                        state_d = SPLIT;
                        stall_d = 1'b1;
                    end
                end else if (!bus.flush && ex_ld) begin
                    re_d    = 1'b1;
                    addr_d  = bus.ex_addr >> 3;
                    off_d   = ex_off;
                    be_d    = 8'h00;
                    wdata_d = '0;
                end
            end
            SPLIT: begin
                // The held store predates any flush, so beat 1 always goes out.
                we_d    = 1'b1;
                addr_d  = addr_q + ADDR_W_P'(1);
                be_d    = pend_be_q;
                wdata_d = pend_wdata_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q      <= IDLE;
            we_q         <= 1'b0;
            re_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            be_q         <= 8'h00;
            off_q        <= 3'd0;
            stall_q      <= 1'b0;
            pend_wdata_q <= '0;
            pend_be_q    <= 8'h00;
        end else begin
            state_q      <= state_d;
            we_q         <= we_d;
            re_q         <= re_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            be_q         <= be_d;
            off_q        <= off_d;
            stall_q      <= stall_d;
            pend_wdata_q <= pend_wdata_d;
            pend_be_q    <= pend_be_d;
        end
    end

    assign bus.mem_we       = we_q;
    assign bus.mem_re       = re_q;
    assign bus.mem_addr     = addr_q;
    assign bus.mem_wdata    = wdata_q;
    assign bus.mem_be       = be_q;
    assign bus.ew_ld_offset = off_q;
    assign bus.stall_st     = stall_q;

`ifdef STORE_ISSUE_PERF_EN
    // Counters advance with the registered strobe so they track visible beats.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            st_beat_cnt  <= 32'd0;
            st_split_cnt <= 32'd0;
        end else begin
            if (we_d && (st_beat_cnt != 32'hFFFF_FFFF))
                st_beat_cnt <= st_beat_cnt + 32'd1;
            if ((state_q == IDLE) && (state_d == SPLIT) && (st_split_cnt != 32'hFFFF_FFFF))
                st_split_cnt <= st_split_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_store_issue_phase.sv
// Bench for store_issue_phase: directed cases followed by random ops, scored against a byte-window model.
module tb_store_issue_phase;
    import store_issue_phase_pkg::*;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    store_issue_phase_if bus ();

`ifdef STORE_ISSUE_PERF_EN
    logic [31:0] st_beat_cnt;
    logic [31:0] st_split_cnt;
`endif

    store_issue_phase dut (
        .clk          (clk),
        .rstn         (rstn),
        .bus          (bus)
`ifdef STORE_ISSUE_PERF_EN
        ,
        .st_beat_cnt  (st_beat_cnt),
        .st_split_cnt (st_split_cnt)
`endif
    );

    int checks = 0;
    int errors = 0;

    // Expected visible outputs plus the queued second beat of a split store
    logic        m_we, m_re, m_stall, m_pend;
    logic [31:0] m_addr;
    logic [63:0] m_wdata, m_pwdata;
    logic [7:0]  m_be, m_pbe;
    logic [2:0]  m_off;
    longint      m_beats, m_splits;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%h expected=%h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int acc_bytes(input logic [7:0] op);
        if (op == MICRO_SB || op == MICRO_LB) return 1;
        if (op == MICRO_SD || op == MICRO_LD) return 4;
        if (op == MICRO_SQ || op == MICRO_LQ) return 8;
        return 0;
    endfunction

    task automatic model_reset();
        m_we = 0; m_re = 0; m_stall = 0; m_pend = 0;
        m_addr = 0; m_wdata = 0; m_pwdata = 0; m_be = 0; m_pbe = 0; m_off = 0;
        m_beats = 0; m_splits = 0;
    endtask

    // Expected outputs after the next rising edge, given the inputs now presented.
    task automatic model_edge();
        int           n, off;
        logic         st;
        logic [127:0] win;
        logic [15:0]  bw;
        if (m_pend) begin
            m_we = 1; m_re = 0; m_stall = 0; m_pend = 0;
            m_addr  = m_addr + 32'd1;
            m_be    = m_pbe;
            m_wdata = m_pwdata;
        end else begin
            m_we = 0; m_re = 0; m_stall = 0;
            n   = acc_bytes(bus.ex_opcode);
            off = int'(bus.ex_addr[2:0]);
            st  = (bus.ex_opcode == MICRO_SB) || (bus.ex_opcode == MICRO_SD) ||
                  (bus.ex_opcode == MICRO_SQ);
            if (!bus.flush && n != 0) begin
                m_addr = bus.ex_addr >> 3;
                if (st) begin
                    // Place the store in a two-word window; low word is beat 0, high word beat 1.
                    win = {64'd0, bus.ex_st_data} << (8 * off);
                    bw  = ((16'd1 << n) - 16'd1) << off;
                    m_we = 1;
                    m_wdata = win[63:0];
                    m_be    = bw[7:0];
                    if (off + n > 8) begin
                        m_pend = 1; m_stall = 1; m_splits++;
                        m_pwdata = win[127:64];
                        m_pbe    = bw[15:8];
                    end
                end else begin
                    m_re = 1;
                    m_off = 3'(off);
                    m_be = 0;
                    m_wdata = 0;
                end
            end
        end
        if (m_we) m_beats++;
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, ".we"},    64'(bus.mem_we),       64'(m_we));
        chk({tag, ".re"},    64'(bus.mem_re),       64'(m_re));
        chk({tag, ".addr"},  64'(bus.mem_addr),     64'(m_addr));
        chk({tag, ".wdata"}, bus.mem_wdata,         m_wdata);
        chk({tag, ".be"},    64'(bus.mem_be),       64'(m_be));
        chk({tag, ".off"},   64'(bus.ew_ld_offset), 64'(m_off));
        chk({tag, ".stall"}, 64'(bus.stall_st),     64'(m_stall));
        chk({tag, ".excl"},  64'(bus.mem_we & bus.mem_re), 64'd0);
`ifdef STORE_ISSUE_PERF_EN
        chk({tag, ".beatcnt"},  64'(st_beat_cnt),  64'(m_beats));
        chk({tag, ".splitcnt"}, 64'(st_split_cnt), 64'(m_splits));
`endif
    endtask

    task automatic drive(input logic [7:0] op, input logic [31:0] a, input logic [63:0] d,
                         input logic fl);
        bus.ex_opcode  = op;
        bus.ex_addr    = a;
        bus.ex_st_data = d;
        bus.flush      = fl;
    endtask

    task automatic cycle(input string tag);
        model_edge();
        @(posedge clk);
        #1;
        check_outputs(tag);
    endtask

    function automatic logic [7:0] rand_op();
        case ($urandom_range(0, 7))
            0: return MICRO_SB;
            1: return MICRO_SD;
            2: return MICRO_SQ;
            3: return MICRO_LB;
            4: return MICRO_LD;
            5: return MICRO_LQ;
            6: return 8'h00;
            default: return 8'h3C;
        endcase
    endfunction

    initial begin
        drive(8'h00, 32'h0, 64'h0, 1'b0);
        model_reset();
        #3;
        check_outputs("reset");
        @(posedge clk);
        #1;
        rstn = 1'b1;

        drive(MICRO_SQ, 32'h10, 64'h1122334455667788, 1'b0);
        cycle("sq_aligned");
        chk("sq_aligned.be_const", 64'(bus.mem_be), 64'hFF);

        drive(MICRO_SB, 32'h0D, 64'hAB, 1'b0);
        cycle("sb_off5");
        chk("sb_off5.wdata_const", bus.mem_wdata, 64'h0000AB0000000000);

        drive(MICRO_SD, 32'h06, 64'hDDCCBBAA, 1'b0);
        cycle("sd_beat0");
        chk("sd_beat0.be_const", 64'(bus.mem_be), 64'hC0);
        chk("sd_beat0.stall_const", 64'(bus.stall_st), 64'd1);
        drive(MICRO_LB, 32'h23, 64'h0, 1'b0);
        cycle("sd_beat1");
        chk("sd_beat1.wdata_const", bus.mem_wdata, 64'h000000000000DDCC);
        cycle("lb_held");
        chk("lb_held.off_const", 64'(bus.ew_ld_offset), 64'd3);

        drive(MICRO_SQ, 32'h05, 64'h0102030405060708, 1'b0);
        cycle("sq_split_beat0");
        drive(8'h00, 32'h0, 64'h0, 1'b1);
        cycle("sq_split_flush");
        chk("sq_split_flush.be_const", 64'(bus.mem_be), 64'h1F);
        drive(MICRO_SB, 32'h40, 64'h55, 1'b1);
        cycle("sb_flushed");

        drive(MICRO_SD, 32'hFFFF_FFFD, 64'hCAFEF00D, 1'b0);
        cycle("sd_top_beat0");
        drive(MICRO_LQ, 32'h0000_0FFF, 64'h0, 1'b0);
        cycle("sd_top_beat1");
        cycle("lq_cross");

        drive(MICRO_SQ, 32'h07, {$urandom, $urandom}, 1'b0);
        cycle("rst_split_beat0");
        drive(8'h00, 32'h0, 64'h0, 1'b0);
        #3;
        rstn = 1'b0;
        #1;
        model_reset();
        check_outputs("rst_async");
        @(posedge clk);
        #1;
        check_outputs("rst_held");
        rstn = 1'b1;
        drive(MICRO_SB, 32'h0D, 64'hAB, 1'b0);
        cycle("after_rst");

        for (int i = 0; i < 400; i++) begin
            if (!m_stall)
                drive(rand_op(), $urandom_range(0, 255), {$urandom, $urandom}, 1'b0);
            bus.flush = ($urandom_range(0, 7) == 0);
            cycle("rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
